// File: rtl/turbo_bus_pkg.sv
// Shared bus-frame definitions for the stream/bus conversion stages around the
// turbo decoder: widths, header layout and the header builder.
package turbo_bus_pkg;

  localparam int BUS         = 512;
  localparam int BUS_HEAD    = 16;
  localparam int BUS_PAYLOAD = BUS - BUS_HEAD;
  localparam int ST          = 8;
  localparam int W_BUS_IDX   = 11;
  localparam int W_ST_CNT    = 16;
  localparam int N_SLOT      = BUS_PAYLOAD / ST;
  localparam int SLOT_W      = $clog2(N_SLOT);
  localparam int HDR_FIRST   = BUS_HEAD - 1;
  localparam int HDR_LAST    = BUS_HEAD - 2;

  // Header layout, MSB first: first-word flag, last-word flag, zero gap, word index.
  typedef struct packed {
    logic                              first;
    logic                              last;
    logic [BUS_HEAD-3-W_BUS_IDX:0]     rsvd;
    logic [W_BUS_IDX-1:0]              idx;
  } bus_hdr_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PACK = 1'b1
  } st2bus_state_t;

  function automatic bus_hdr_t make_hdr(input logic first,
                                        input logic last,
                                        input logic [W_BUS_IDX-1:0] idx);
    bus_hdr_t h;
    h.first = first;
    h.last  = last;
    h.rsvd  = '0;
    h.idx   = idx;
    return h;
  endfunction

endpackage

// File: rtl/st2bus_pack.sv
// Slot counter and partial payload register. The payload output already
// contains the symbol of the current beat, so a closing beat yields the
// complete word in the same cycle.
module st2bus_pack
  import turbo_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beat,
  input  logic                   eop,
  input  logic [ST-1:0]          data,
  output logic                   word_close,
  output logic [BUS_PAYLOAD-1:0] payload,
  output logic                   last
);

  logic [SLOT_W-1:0]      slot_r;
  logic [BUS_PAYLOAD-1:0] payload_r;

  // Merge the incoming symbol into its slot and detect the closing beat.
  always_comb begin
    payload    = payload_r;
    word_close = 1'b0;
    last       = 1'b0;
    if (beat) begin
      payload[slot_r*ST +: ST] = data;
      word_close = (slot_r == SLOT_W'(N_SLOT - 1)) | eop;
      last       = eop;
    end else begin
      word_close = 1'b0;
      last       = 1'b0;
    end
  end

  // Advance the slot counter; a closed word leaves an empty register behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r    <= '0;
      payload_r <= '0;
    end else if (word_close) begin
      slot_r    <= '0;
      payload_r <= '0;
    end else if (beat) begin
      slot_r    <= slot_r + SLOT_W'(1);
      payload_r <= payload;
    end
  end

endmodule

// File: rtl/st2bus.sv
// Packs Avalon-ST decoder output into header-tagged bus words, one bus frame
// per stream frame, with a single-entry output register toward memory.
module st2bus
  import turbo_bus_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ST-1:0]       st_data,
  input  logic                st_valid,
  input  logic                st_sop,
  input  logic                st_eop,
  output logic                st_ready,
  output logic [BUS-1:0]      bus_data,
  output logic                bus_en,
  input  logic                bus_ready,
  output logic                frm_done,
  output logic [W_ST_CNT-1:0] frm_st_len,
  output logic                err_proto
);

  st2bus_state_t          state_r, next_state_s;
  logic                   accept_s, data_beat_s, frame_start_s, proto_err_s;
  logic                   word_close_s, last_s;
  logic [BUS_PAYLOAD-1:0] payload_s;

  logic                   first_r, cur_first_s;
  logic [W_BUS_IDX-1:0]   idx_r, cur_idx_s;
  logic [W_ST_CNT-1:0]    cnt_r, cur_cnt_s;

  logic                   pend_r, pend_last_r;
  logic [W_ST_CNT-1:0]    pend_cnt_r;

  // A new word can always be taken when the output slot is free or draining.
  assign st_ready = ~pend_r | bus_ready;
  assign accept_s = st_valid & st_ready;
  assign bus_en   = pend_r & bus_ready;
  assign frm_done = bus_en & pend_last_r;

  // Frame FSM: classify each accepted beat as data, frame start or protocol error.
  always_comb begin
    next_state_s  = state_r;
    data_beat_s   = 1'b0;
    frame_start_s = 1'b0;
    proto_err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (st_sop) begin
            data_beat_s   = 1'b1;
            frame_start_s = 1'b1;
            next_state_s  = st_eop ? S_IDLE : S_PACK;
          end else begin
            proto_err_s = 1'b1;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_PACK: begin
        if (accept_s) begin
          data_beat_s  = 1'b1;
          proto_err_s  = st_sop;
          next_state_s = st_eop ? S_IDLE : S_PACK;
        end else begin
          next_state_s = S_PACK;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Per-frame values seen by the current beat; a frame start restarts them.
  always_comb begin
    cur_first_s = frame_start_s ? 1'b1 : first_r;
    cur_idx_s   = frame_start_s ? '0 : idx_r;
    cur_cnt_s   = frame_start_s ? W_ST_CNT'(1) : cnt_r + W_ST_CNT'(1);
  end

  // Frame counters: first-word flag, word index and accepted-symbol count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_r <= 1'b0;
      idx_r   <= '0;
      cnt_r   <= '0;
    end else if (data_beat_s) begin
      first_r <= word_close_s ? 1'b0 : cur_first_s;
      idx_r   <= word_close_s ? cur_idx_s + W_BUS_IDX'(1) : cur_idx_s;
      cnt_r   <= cur_cnt_s;
    end
  end

  st2bus_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .beat       (data_beat_s),
    .eop        (st_eop),
    .data       (st_data),
    .word_close (word_close_s),
    .payload    (payload_s),
    .last       (last_s)
  );

  // Output register: a closing word loads even while the previous one drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_data    <= '0;
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
      pend_cnt_r  <= '0;
    end else if (word_close_s) begin
      bus_data    <= {payload_s, make_hdr(cur_first_s, last_s, cur_idx_s)};
      pend_r      <= 1'b1;
      pend_last_r <= last_s;
      pend_cnt_r  <= cur_cnt_s;
    end else if (bus_en) begin
      pend_r      <= 1'b0;
    end
  end

  // Publish the frame length once its last word has left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_st_len <= '0;
    end else if (frm_done) begin
      frm_st_len <= pend_cnt_r;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_proto <= 1'b0;
    end else if (proto_err_s) begin
      err_proto <= 1'b1;
    end
  end

endmodule

// File: tb/tb_st2bus.sv
// Directed bench for st2bus: a frame-level model builds the expected word
// stream, and a monitor compares every transferred word against it.
module tb_st2bus;
  import turbo_bus_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [ST-1:0]       st_data;
  logic                st_valid, st_sop, st_eop, st_ready;
  logic [BUS-1:0]      bus_data;
  logic                bus_en, bus_ready, frm_done, err_proto;
  logic [W_ST_CNT-1:0] frm_st_len;

  always #5 clk = ~clk;

  st2bus dut (
    .clk(clk), .rst(rst), .st_data(st_data), .st_valid(st_valid),
    .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready),
    .bus_data(bus_data), .bus_en(bus_en), .bus_ready(bus_ready),
    .frm_done(frm_done), .frm_st_len(frm_st_len), .err_proto(err_proto)
  );

  typedef struct {
    logic [BUS-1:0] data;
    bit             last;
    int             len;
  } exp_word_t;

  exp_word_t           exp_q[$];
  logic [15:0]         got_hdr[$];
  logic [BUS-1:0]      last_word = '0;
  int                  checks = 0;
  int                  failures = 0;
  bit                  mon_on = 1'b0;
  logic                exp_err = 1'b0;
  logic [W_ST_CNT-1:0] exp_len = '0;

  task automatic chk(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected words of a complete frame of n symbols valued (base+i) mod 256.
  task automatic model_frame(input int n, input int base);
    int nw;
    nw = (n + N_SLOT - 1) / N_SLOT;
    for (int w = 0; w < nw; w++) begin
      exp_word_t e;
      logic [15:0] h;
      h = {(w == 0), (w == nw - 1), 3'b000, 11'(w)};
      e.data = '0;
      e.data[15:0] = h;
      for (int k = 0; k < N_SLOT; k++) begin
        if (w * N_SLOT + k < n) e.data[BUS_HEAD + k*ST +: ST] = 8'(base + w * N_SLOT + k);
      end
      e.last = (w == nw - 1);
      e.len  = n;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare every cycle against the model.
  always @(negedge clk) begin
    exp_word_t w;
    if (mon_on && !rst) begin
      chk("frm_st_len", frm_st_len, exp_len);
      chk("err_proto", err_proto, exp_err);
      if (bus_en) begin
        chk("bus_en_needs_ready", bus_ready, 1'b1);
        got_hdr.push_back(bus_data[15:0]);
        last_word = bus_data;
        chk("word_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("bus_data", bus_data, w.data);
          chk("frm_done", frm_done, w.last);
          if (w.last) exp_len = w.len[W_ST_CNT-1:0];
        end
      end else begin
        chk("frm_done_idle", frm_done, 1'b0);
      end
    end
  end

  // Offer one beat, holding it until the DUT accepts it (bounded).
  task automatic send(input logic [ST-1:0] d, input logic sop, input logic eop);
    int guard;
    bit ok;
    guard = 0;
    st_data = d; st_sop = sop; st_eop = eop; st_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = st_ready;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 100) begin
        chk("accept_timeout", ok, 1'b1);
        break;
      end
    end
    st_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base);
    model_frame(n, base);
    for (int i = 0; i < n; i++) send(8'(base + i), (i == 0), (i == n - 1));
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_st_ready"}, st_ready, 1'b1);
    chk({tag, "_bus_en"}, bus_en, 1'b0);
    chk({tag, "_bus_data"}, bus_data, '0);
    chk({tag, "_frm_done"}, frm_done, 1'b0);
    chk({tag, "_frm_st_len"}, frm_st_len, 16'd0);
    chk({tag, "_err_proto"}, err_proto, 1'b0);
  endtask

  initial begin
    time t0;
    rst = 1'b1; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = '0; bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // One full word: 62 symbols 0..61.
    got_hdr.delete();
    send_frame(62, 0);
    @(negedge clk);
    chk("t1_bus_en_t1", bus_en, 1'b1);
    chk("t1_frm_done_t1", frm_done, 1'b1);
    @(posedge clk); #1;
    chk("t1_len", frm_st_len, 16'd62);
    chk("t1_nwords", got_hdr.size(), 1);
    if (got_hdr.size() > 0) chk("t1_hdr", got_hdr[0], 16'hC000);
    chk("t1_sym61", last_word[BUS_HEAD + 61*ST +: ST], 8'd61);

    // Two words: 100 symbols.
    got_hdr.delete();
    send_frame(100, 0);
    wait_drain();
    chk("t2_nwords", got_hdr.size(), 2);
    if (got_hdr.size() == 2) begin
      chk("t2_hdr0", got_hdr[0], 16'h8000);
      chk("t2_hdr1", got_hdr[1], 16'h4001);
    end
    chk("t2_upper_slots_zero", last_word[BUS-1:BUS_HEAD + 38*ST], '0);
    chk("t2_sym99", last_word[BUS_HEAD + 37*ST +: ST], 8'd99);
    chk("t2_len", frm_st_len, 16'd100);

    // Backpressure: memory stalls for 10 cycles right after the first word closes.
    model_frame(100, 7);
    for (int i = 0; i < 61; i++) send(8'(7 + i), (i == 0), 1'b0);
    bus_ready = 1'b0;
    send(8'(7 + 61), 1'b0, 1'b0);
    st_data = 8'(7 + 62); st_sop = 1'b0; st_eop = 1'b0; st_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t3_st_ready_low", st_ready, 1'b0);
      chk("t3_no_bus_en", bus_en, 1'b0);
      @(posedge clk); #1;
    end
    bus_ready = 1'b1;
    for (int i = 62; i < 100; i++) send(8'(7 + i), 1'b0, (i == 99));
    wait_drain();
    chk("t3_len", frm_st_len, 16'd100);

    // Back-to-back single-symbol frames, one per cycle.
    got_hdr.delete();
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      model_frame(1, 40 + i);
      send(8'(40 + i), 1'b1, 1'b1);
    end
    chk("t4_one_per_cycle", 64'($time - t0), 64'd80);
    wait_drain();
    chk("t4_nwords", got_hdr.size(), 8);
    foreach (got_hdr[i]) chk("t4_hdr", got_hdr[i], 16'hC000);
    chk("t4_len", frm_st_len, 16'd1);

    // Beat without sop while idle is dropped and flags an error.
    send(8'hAA, 1'b0, 1'b0);
    exp_err = 1'b1;
    send_frame(5, 200);
    wait_drain();
    chk("t5_err_sticky", err_proto, 1'b1);
    chk("t5_len", frm_st_len, 16'd5);

    // Reset in the middle of a frame discards it.
    for (int i = 0; i < 30; i++) send(8'(i), (i == 0), 1'b0);
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    exp_err = 1'b0;
    exp_len = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;
    got_hdr.delete();
    send_frame(62, 9);
    wait_drain();
    chk("t6_nwords", got_hdr.size(), 1);
    if (got_hdr.size() > 0) chk("t6_hdr", got_hdr[0], 16'hC000);
    chk("t6_len", frm_st_len, 16'd62);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
